// File: rtl/mau_pkg.sv
// Shared definitions for the data-memory access unit: op encodings, FSM states, memory size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mau_pkg;

    // Number of implemented data-memory words; addresses at or above this are out of range.
    localparam int unsigned MAU_MEM_WORDS_DEFAULT = 100;

    typedef enum logic [1:0] {
        OP_LW = 2'b00,
        OP_SW = 2'b01,
        OP_LM = 2'b10,
        OP_SM = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_MULTI  = 2'd2
    } state_t;

    // LM and SM share the upper encoding bit.
    function automatic logic is_multi(input op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/mem_access_unit_lsb_pick.sv
// Lowest-set-bit picker for the LM/SM register mask.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   mask      - remaining register mask
//   idx       - index of the lowest set bit (0 when mask is zero)
//   rest      - mask with that bit cleared
//   last      - rest is empty, i.e. this pick consumes the final bit
module lsb_pick (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic [7:0] rest,
    output logic       last
);

    // Scan from the top down so the lowest set bit is the final assignment.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
            end
        end
    end

    // Classic x & (x-1) clears the lowest set bit.
    assign rest = mask & (mask - 8'd1);
    assign last = (rest == 8'd0);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: LW/SW single accesses and LM/SM mask-driven bursts.
// Latency: access in the cycle after accept, done one cycle after the last access.
// Backpressure: req_ready is low from accept until the done cycle; requests must be held.
//
// Ports:
//   clk, reset_n                          - clock, synchronous active-low reset
//   req_valid/req_ready, req_op, req_addr,
//   req_mask, req_sdata, req_rd           - request handshake and operands
//   rf_rd_addr / rf_rd_data               - register-file read for SM store data
//   mem_addr, mem_wdata, mem_w, mem_rdata - data-memory port (rdata combinational)
//   wb_en, wb_addr, wb_data               - registered load write-back
//   done, err                             - completion pulse and out-of-range qualifier
import mau_pkg::*;

module mem_access_unit #(
    parameter int unsigned MEM_WORDS = MAU_MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_mask,
    input  logic [15:0] req_sdata,
    input  logic [2:0]  req_rd,
    output logic [2:0]  rf_rd_addr,
    input  logic [15:0] rf_rd_data,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_w,
    input  logic [15:0] mem_rdata,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        done,
    output logic        err
);

    state_t      state;
    op_t         op_q;
    logic [15:0] addr_q;
    logic [7:0]  mask_q;
    logic [15:0] sdata_q;
    logic [2:0]  rd_q;
    logic [2:0]  k_q;      // accesses already issued in the current burst
    logic        err_q;    // sticky out-of-range flag for the current burst

    logic [2:0]  pick_idx;
    logic [7:0]  pick_rest;
    logic        pick_last;

    logic [15:0] slot_addr;
    logic        slot_oor;
    logic        single_access;

    lsb_pick u_lsb_pick (
        .mask (mask_q),
        .idx  (pick_idx),
        .rest (pick_rest),
        .last (pick_last)
    );

    assign req_ready = (state == ST_IDLE);

    // Burst addresses wrap naturally in 16 bits (FFFF -> 0000).
    assign slot_addr = (state == ST_MULTI) ? (addr_q + {13'd0, k_q}) : addr_q;
    assign slot_oor  = (32'(slot_addr) >= MEM_WORDS);

    // A SINGLE slot holding LM/SM is the zero-mask no-op: no access, no error.
    assign single_access = !is_multi(op_q);

    // Memory-side outputs are decoded from registered state only (plus rf_rd_data),
    // so they settle well before the memory's negedge write.
    always_comb begin
        mem_addr   = 16'd0;
        mem_wdata  = 16'd0;
        mem_w      = 1'b0;
        rf_rd_addr = 3'd0;
        case (state)
            ST_SINGLE: begin
                mem_addr = slot_addr;
                if (op_q == OP_SW) begin
                    mem_wdata = sdata_q;
                    mem_w     = !slot_oor;
                end
            end
            ST_MULTI: begin
                mem_addr = slot_addr;
                if (op_q == OP_SM) begin
                    rf_rd_addr = pick_idx;
                    mem_wdata  = rf_rd_data;
                    mem_w      = !slot_oor;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= 16'd0;
            mask_q  <= 8'd0;
            sdata_q <= 16'd0;
            rd_q    <= 3'd0;
            k_q     <= 3'd0;
            err_q   <= 1'b0;
            wb_en   <= 1'b0;
            wb_addr <= 3'd0;
            wb_data <= 16'd0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_t'(req_op);
                        addr_q  <= req_addr;
                        mask_q  <= req_mask;
                        sdata_q <= req_sdata;
                        rd_q    <= req_rd;
                        k_q     <= 3'd0;
                        err_q   <= 1'b0;
                        if (is_multi(op_t'(req_op)) && (req_mask != 8'd0)) begin
                            state <= ST_MULTI;
                        end else begin
                            state <= ST_SINGLE;
                        end
                    end
                end
                ST_SINGLE: begin
                    if (op_q == OP_LW) begin
                        wb_en   <= 1'b1;
                        wb_addr <= rd_q;
                        wb_data <= slot_oor ? 16'h0000 : mem_rdata;
                    end
                    done  <= 1'b1;
                    err   <= single_access && slot_oor;
                    state <= ST_IDLE;
                end
                ST_MULTI: begin
                    if (op_q == OP_LM) begin
                        wb_en   <= 1'b1;
                        wb_addr <= pick_idx;
                        wb_data <= slot_oor ? 16'h0000 : mem_rdata;
                    end
                    mask_q <= pick_rest;
                    k_q    <= k_q + 3'd1;
                    err_q  <= err_q | slot_oor;
                    if (pick_last) begin
                        done  <= 1'b1;
                        err   <= err_q | slot_oor;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic [7:0]  req_mask;
    logic [15:0] req_sdata;
    logic [2:0]  req_rd;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_w;
    logic [15:0] mem_rdata;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        done;
    logic        err;

    mem_access_unit #(.MEM_WORDS(100)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_mask   (req_mask),
        .req_sdata  (req_sdata),
        .req_rd     (req_rd),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_w      (mem_w),
        .mem_rdata  (mem_rdata),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Environment: memory and register file seen by the DUT.
    logic [15:0] mem [0:127];
    logic [15:0] rf  [0:7];
    // Reference model state, advanced when requests are issued.
    logic [15:0] m_mem [0:127];
    logic [15:0] m_rf  [0:7];

    always_comb begin
        mem_rdata = 16'hDEAD;
        if (mem_addr < 16'd100) mem_rdata = mem[mem_addr[6:0]];
    end
    assign rf_rd_data = rf[rf_rd_addr];

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;

    ev_t  memq [$];
    ev_t  wbq  [$];
    logic errq [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_%s: got 1 expected 0 (no pending entry)", name);
    endtask

    // Model: compute every write, write-back and completion the request should cause.
    task automatic push_req(input logic [1:0] op, input logic [15:0] addr,
                            input logic [7:0] mask, input logic [15:0] sdata,
                            input logic [2:0] rd);
        logic [15:0] a;
        logic [15:0] v;
        logic        o;
        logic        e;
        int          k;
        o = (addr >= 16'd100);
        case (op)
            2'b00: begin
                v = o ? 16'h0000 : m_mem[addr[6:0]];
                wbq.push_back('{16'(rd), v});
                m_rf[rd] = v;
                errq.push_back(o);
            end
            2'b01: begin
                if (!o) begin
                    memq.push_back('{addr, sdata});
                    m_mem[addr[6:0]] = sdata;
                end
                errq.push_back(o);
            end
            default: begin
                k = 0;
                e = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (mask[i]) begin
                        a = addr + 16'(k);
                        o = (a >= 16'd100);
                        if (op == 2'b10) begin
                            v = o ? 16'h0000 : m_mem[a[6:0]];
                            wbq.push_back('{16'(i), v});
                            m_rf[i] = v;
                        end else if (!o) begin
                            memq.push_back('{a, m_rf[i]});
                            m_mem[a[6:0]] = m_rf[i];
                        end
                        e = e | o;
                        k++;
                    end
                end
                errq.push_back(e);
            end
        endcase
    endtask

    // Monitor: sampled on the negedge, where the memory also commits writes.
    always @(negedge clk) begin
        ev_t  e;
        logic x;
        if (mem_w === 1'b1) begin
            if (memq.size() == 0) unexpected("mem_w");
            else begin
                e = memq.pop_front();
                chk("memw_addr", 32'(mem_addr), 32'(e.a));
                chk("memw_data", 32'(mem_wdata), 32'(e.d));
            end
            if (mem_addr < 16'd128) mem[mem_addr[6:0]] <= mem_wdata;
        end
        if (wb_en === 1'b1) begin
            if (wbq.size() == 0) unexpected("wb_en");
            else begin
                e = wbq.pop_front();
                chk("wb_addr", 32'(wb_addr), 32'(e.a));
                chk("wb_data", 32'(wb_data), 32'(e.d));
            end
            rf[wb_addr] <= wb_data;
        end
        if (done === 1'b1) begin
            if (errq.size() == 0) unexpected("done");
            else begin
                x = errq.pop_front();
                chk("done_err", 32'(err), 32'(x));
            end
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [7:0]  mask;
        logic [15:0] sdata;
        logic [2:0]  rd;
        int          lat;
        logic        err;
    } vec_t;

    vec_t vecs [12];

    // Issue one request, then measure cycles from the accept edge to done.
    task automatic send(input vec_t v, output int lat, output logic got_err);
        @(negedge clk);
        for (int w = 0; w < 50 && req_ready !== 1'b1; w++) @(negedge clk);
        req_op    = v.op;
        req_addr  = v.addr;
        req_mask  = v.mask;
        req_sdata = v.sdata;
        req_rd    = v.rd;
        req_valid = 1'b1;
        push_req(v.op, v.addr, v.mask, v.sdata, v.rd);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got_err = 1'bx;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                got_err = err;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        int   cnt;
        int   dcnt;
        logic ge;
        logic seen;

        for (int i = 0; i < 128; i++) begin
            mem[i]   = 16'h1000 + 16'(i);
            m_mem[i] = 16'h1000 + 16'(i);
        end
        mem[5] = 16'hBEEF;  m_mem[5] = 16'hBEEF;
        mem[0] = 16'hC0DE;  m_mem[0] = 16'hC0DE;
        rf[0] = 16'h0001; rf[1] = 16'h0011; rf[2] = 16'h0002; rf[3] = 16'h0033;
        rf[4] = 16'h0044; rf[5] = 16'h0055; rf[6] = 16'h0066; rf[7] = 16'h0007;
        for (int i = 0; i < 8; i++) m_rf[i] = rf[i];

        //                op     addr       mask   sdata      rd  lat err
        vecs[0]  = '{2'b00, 16'd5,    8'h00, 16'h0000, 3'd3, 2, 1'b0};
        vecs[1]  = '{2'b11, 16'd10,   8'h85, 16'h0000, 3'd0, 4, 1'b0};
        vecs[2]  = '{2'b10, 16'hFFFF, 8'h03, 16'h0000, 3'd0, 3, 1'b1};
        vecs[3]  = '{2'b10, 16'd40,   8'h00, 16'h0000, 3'd0, 2, 1'b0};
        vecs[4]  = '{2'b01, 16'd99,   8'h00, 16'hA5A5, 3'd0, 2, 1'b0};
        vecs[5]  = '{2'b01, 16'd100,  8'h00, 16'h5A5A, 3'd0, 2, 1'b1};
        vecs[6]  = '{2'b00, 16'd100,  8'h00, 16'h0000, 3'd6, 2, 1'b1};
        vecs[7]  = '{2'b00, 16'd11,   8'h00, 16'h0000, 3'd4, 2, 1'b0};
        vecs[8]  = '{2'b10, 16'd10,   8'hF0, 16'h0000, 3'd0, 5, 1'b0};
        vecs[9]  = '{2'b11, 16'd96,   8'hFF, 16'h0000, 3'd0, 9, 1'b1};
        vecs[10] = '{2'b11, 16'd50,   8'h00, 16'h0000, 3'd0, 2, 1'b0};
        vecs[11] = '{2'b00, 16'd96,   8'h00, 16'h0000, 3'd0, 2, 1'b0};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = 16'd0;
        req_mask  = 8'd0;
        req_sdata = 16'd0;
        req_rd    = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_wb_en",     32'(wb_en), 32'd0);
        chk("rst_done",      32'(done), 32'd0);
        chk("rst_err",       32'(err), 32'd0);
        chk("rst_mem_w",     32'(mem_w), 32'd0);
        chk("rst_mem_addr",  32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_wb_data",   32'(wb_data), 32'd0);
        chk("rst_wb_addr",   32'(wb_addr), 32'd0);
        chk("rst_rf_rd_addr", 32'(rf_rd_addr), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send(vecs[i], lat, ge);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].err));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // SM with a full mask, reset asserted at the edge closing the third access.
        @(negedge clk);
        req_op = 2'b11; req_addr = 16'd20; req_mask = 8'hFF; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            memq.push_back('{16'd20 + 16'(i), m_rf[i]});
            m_mem[20 + i] = m_rf[i];
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_mem_w", 32'(mem_w), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        chk("abort_writes_drained", 32'(memq.size()), 32'd0);

        // SW then LW to the same address, LW held on req_valid throughout.
        @(negedge clk);
        req_op = 2'b01; req_addr = 16'd30; req_sdata = 16'h1234; req_valid = 1'b1;
        push_req(2'b01, 16'd30, 8'h00, 16'h1234, 3'd0);
        push_req(2'b00, 16'd30, 8'h00, 16'h0000, 3'd5);
        @(posedge clk);
        #1 req_op = 2'b00; req_rd = 3'd5;
        cnt = 0;
        seen = 1'b0;
        while (cnt < 20 && !seen) begin
            @(negedge clk);
            cnt++;
            if (req_ready === 1'b1) seen = 1'b1;
        end
        chk("b2b_ready_cycle", 32'(cnt), 32'd2);
        chk("b2b_done_with_ready", 32'(done), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cnt++;
            if (done === 1'b1) break;
        end
        chk("b2b_lw_latency", 32'(cnt), 32'd2);
        repeat (3) @(negedge clk);
        chk("rf5_after_b2b", 32'(rf[5]), 32'h1234);

        chk("memq_empty", 32'(memq.size()), 32'd0);
        chk("wbq_empty",  32'(wbq.size()), 32'd0);
        chk("errq_empty", 32'(errq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the pipeline's data-memory port: the MEM-stage controller that drives the data memory's address, write-data and write-strobe, and captures its combinational read data. It executes single-word LW/SW and multi-word LM/SM by sequencing one memory access per cycle from an 8-bit register mask. It returns load results as register write-backs and holds the pipeline off via `req_ready` while busy.

## Interface
- `MEM_WORDS`, default 100: number of implemented memory words; addresses >= MEM_WORDS are out of range.
- `clk` in 1: clock; all state updates on posedge.
- `reset_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: MEM-stage request present.
- `req_ready` out 1: unit idle, request accepted when `req_valid & req_ready`.
- `req_op` in 2: 00 LW, 01 SW, 10 LM, 11 SM.
- `req_addr` in 16: effective/base address.
- `req_mask` in 8: LM/SM mask, bit i selects Ri; ignored for LW/SW.
- `req_sdata` in 16: SW store data.
- `req_rd` in 3: LW destination register.
- `rf_rd_addr` out 3: register-file read index for SM.
- `rf_rd_data` in 16: register-file read data, combinational from `rf_rd_addr`.
- `mem_addr` out 16, `mem_wdata` out 16, `mem_w` out 1: memory request.
- `mem_rdata` in 16: memory read data; valid only while `mem_w`=0.
- `wb_en` out 1, `wb_addr` out 3, `wb_data` out 16: registered load write-back.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; at least one access was out of range.

## Operation
- States: IDLE, SINGLE, MULTI.
- IDLE: `req_ready`=1. On accept, latch op, addr, mask, sdata, rd; clear access counter k and error flag. LW/SW go to SINGLE. LM/SM go to MULTI; a zero mask goes to SINGLE as a no-op slot.
- SINGLE: one access slot.
  - `mem_addr`=latched addr.
  - SW: `mem_w`=1, `mem_wdata`=sdata.
  - LW: `mem_w`=0; capture `mem_rdata` into wb.
  - Next state IDLE with `done`.
- MULTI: i = lowest set bit of the remaining mask; `mem_addr` = base + k (16-bit modulo, wraps FFFF->0000).
  - SM: `rf_rd_addr`=i, `mem_w`=1, `mem_wdata`=`rf_rd_data`.
  - LM: `mem_w`=0; `wb_addr`<=i, `wb_data`<=`mem_rdata`.
  - Each slot clears bit i and increments k.
  - The slot whose clear empties the mask goes to IDLE and issues `done`.
- Out of range (`mem_addr` >= MEM_WORDS):
  - `mem_w` forced 0.
  - Loads write back 16'h0000; `wb_en` still pulses.
  - Set error flag; `err`=1 alongside `done`.
- Outside active slots: `mem_w`=0, `mem_addr`=0, `mem_wdata`=0, `rf_rd_addr`=0.
- `mem_w` is never 1 while `mem_rdata` is sampled.

## Timing
- Reset (sync, `reset_n`=0 at posedge):
  - State becomes IDLE; any in-flight LM/SM is aborted with no further accesses, write-backs or `done`.
  - Outputs: `req_ready`=1; `wb_en`, `done`, `err`, `mem_w`=0; `mem_addr`, `mem_wdata`, `wb_data`=0; `wb_addr`, `rf_rd_addr`=0.
- Memory-side outputs depend only on registered state plus `rf_rd_data`; they must be stable before the memory's negedge write.
- Accept at edge T:
  - LW/SW/zero-mask: access in cycle T+1; `done` (and LW `wb_en`) high in cycle T+2.
  - LM/SM with n set bits: accesses in cycles T+1..T+n; LM `wb_en` in cycles T+2..T+n+1; `done` in cycle T+n+1.
- `wb_en`, `done`, `err` are single-cycle pulses.
- `req_ready` rises in the same cycle as `done`, so back-to-back requests lose no cycle.
- `req_valid` while busy is ignored; the request must be held by the pipeline.

## Structure
- Shared package `mau_pkg`:
  - op encodings `OP_LW`/`OP_SW`/`OP_LM`/`OP_SM`.
  - state enum.
  - `MEM_WORDS` default.
- Sub-module `lsb_pick`: combinational 8-bit priority encoder giving the lowest-set index, the mask with that bit cleared, and a last-bit flag.

## Test plan
- LW addr 5, mem[5]=16'hBEEF, rd=3 -> one slot with `mem_w`=0 at T+1; `wb_en`=1, `wb_addr`=3, `wb_data`=BEEF and `done` at T+2.
- SM addr 10, mask 8'b1000_0101, R0=1, R2=2, R7=7 -> `mem_w`=1 for three cycles writing mem[10]=1, mem[11]=2, mem[12]=7; `done` at T+4.
- LM addr 16'hFFFF, mask 8'b0000_0011 -> second access at 0000 (wrap); FFFF is out of range so R0 gets 0000, R1 gets mem[0]; `err`=1 with `done`.
- LM mask 0 -> no `mem_w`, no `wb_en`; `done` at T+2, `err`=0.
- SM mask 8'hFF, `reset_n`=0 at third access edge -> no further `mem_w`; `done` never pulses; IDLE with `req_ready`=1 next cycle.
- SW then LW to same address held back-to-back on `req_valid` -> LW accepted in SW's `done` cycle and returns the stored value.
